tl_monitor: RTL and testbench

Receive-side companion to the traffic light state machine: consumes its 3-bit state code, drives the six physical lamp lines and independently checks the sequence and the dwell time of every phase. It sits between the controller and the lamp drivers. Violations are flagged as sticky errors for the supervisor, and completed light cycles are counted.

---
 rtl/tl_monitor_if.sv | 35 +++
 rtl/tl_monitor.sv | 151 +++++++++++++++
 tb/tb_tl_monitor.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/tl_monitor_if.sv
// tl_monitor_if: signal bundle between the traffic light controller side and tl_monitor.
//   i_state     : 3-bit state code from the controller
//   i_clr       : clears the sticky error flags
//   o_ns_lamp   : north-south lamps {red, yellow, green}
//   o_ew_lamp   : east-west lamps {red, yellow, green}
//   o_seq_err   : sticky sequence error
//   o_time_err  : sticky dwell-time error
//   o_err_pulse : one-cycle pulse on each new violation
//   o_cycles    : count of completed EY->NS transitions
//   o_dwell     : cycles the current code has been held
// master = controller/supervisor side, slave = monitor.
interface tl_monitor_if #(
  parameter int unsigned T_WIDTH   = 8,
  parameter int unsigned CNT_WIDTH = 16
);
  logic [2:0]           i_state;
  logic                 i_clr;
  logic [2:0]           o_ns_lamp;
  logic [2:0]           o_ew_lamp;
  logic                 o_seq_err;
  logic                 o_time_err;
  logic                 o_err_pulse;
  logic [CNT_WIDTH-1:0] o_cycles;
  logic [T_WIDTH-1:0]   o_dwell;

  modport master (
    output i_state, i_clr,
    input  o_ns_lamp, o_ew_lamp, o_seq_err, o_time_err, o_err_pulse, o_cycles, o_dwell
  );

  modport slave (
    input  i_state, i_clr,
    output o_ns_lamp, o_ew_lamp, o_seq_err, o_time_err, o_err_pulse, o_cycles, o_dwell
  );
endinterface

// File: rtl/tl_monitor.sv
// tl_monitor: receive-side checker for the traffic light controller. Decodes the state code
// into lamp lines, checks phase order and dwell time, flags sticky errors and counts
// completed light cycles. All outputs are registered (1-cycle latency).
// Ports:
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : tl_monitor_if.slave (i_state, i_clr in; lamps, flags, pulse, counters out)
module tl_monitor #(
  parameter int unsigned T_WIDTH   = 8,
  parameter int unsigned NS_CYCLES = 9,
  parameter int unsigned EW_CYCLES = 6,
  parameter int unsigned Y_CYCLES  = 3,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  tl_monitor_if.slave  bus
);

  localparam logic [2:0] CodeStart = 3'b111;
  localparam logic [2:0] CodeNs    = 3'b011;
  localparam logic [2:0] CodeNy    = 3'b010;
  localparam logic [2:0] CodeEw    = 3'b000;
  localparam logic [2:0] CodeEy    = 3'b001;

  localparam logic [2:0] LampRed    = 3'b100;
  localparam logic [2:0] LampYellow = 3'b010;
  localparam logic [2:0] LampGreen  = 3'b001;

  localparam logic [T_WIDTH-1:0] DwellMax = '1;

  logic [2:0]           prev_q;
  logic [T_WIDTH-1:0]   dwell_q, dwell_d;
  logic [2:0]           ns_lamp_q, ns_lamp_d;
  logic [2:0]           ew_lamp_q, ew_lamp_d;
  logic                 seq_err_q, seq_err_d;
  logic                 time_err_q, time_err_d;
  logic                 err_pulse_q;
  logic [CNT_WIDTH-1:0] cycles_q, cycles_d;

  logic                 transition;
  logic                 timed;
  logic [T_WIDTH-1:0]   exp_dwell;
  logic                 succ_valid;
  logic [2:0]           succ;
  logic                 seq_ev;
  logic                 time_ev;

  // Expected dwell and legal successor of the previously held code.
  always_comb begin
    timed      = 1'b0;
    exp_dwell  = '0;
    succ_valid = 1'b1;
    succ       = CodeNs;
    unique case (prev_q)
      CodeStart: succ = CodeNs;
      CodeNs: begin
        timed     = 1'b1;
        exp_dwell = T_WIDTH'(NS_CYCLES);
        succ      = CodeNy;
      end
      CodeNy: begin
        timed     = 1'b1;
        exp_dwell = T_WIDTH'(Y_CYCLES);
        succ      = CodeEw;
      end
      CodeEw: begin
        timed     = 1'b1;
        exp_dwell = T_WIDTH'(EW_CYCLES);
        succ      = CodeEy;
      end
      CodeEy: begin
        timed     = 1'b1;
        exp_dwell = T_WIDTH'(Y_CYCLES);
        succ      = CodeNs;
      end
      // An illegal code has no legal way out.
      default: succ_valid = 1'b0;
    endcase
  end

  // An illegal code can never be a legal successor, so entering one is caught here, and
  // holding one is not a transition, which keeps it to a single error per appearance.
  always_comb begin
    transition = (bus.i_state != prev_q);
    seq_ev     = transition && !(succ_valid && (bus.i_state == succ));
    time_ev    = timed && ((transition && (dwell_q < exp_dwell)) ||
                           (!transition && (dwell_q == exp_dwell)));

    if (transition) begin
      dwell_d = T_WIDTH'(1);
    end else if (dwell_q == DwellMax) begin
      dwell_d = dwell_q;
    end else begin
      dwell_d = dwell_q + T_WIDTH'(1);
    end

    // A new error wins over a same-cycle clear.
    seq_err_d  = (seq_err_q && !bus.i_clr) || seq_ev;
    time_err_d = (time_err_q && !bus.i_clr) || time_ev;

    cycles_d = cycles_q;
    if (transition && (prev_q == CodeEy) && (bus.i_state == CodeNs)) begin
      cycles_d = cycles_q + CNT_WIDTH'(1);
    end
  end

  // Lamp decode of the sampled code.
  always_comb begin
    ns_lamp_d = LampRed;
    ew_lamp_d = LampRed;
    unique case (bus.i_state)
      CodeNs:  ns_lamp_d = LampGreen;
      CodeNy:  ns_lamp_d = LampYellow;
      CodeEw:  ew_lamp_d = LampGreen;
      CodeEy:  ew_lamp_d = LampYellow;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_q      <= CodeStart;
      dwell_q     <= '0;
      ns_lamp_q   <= LampRed;
      ew_lamp_q   <= LampRed;
      seq_err_q   <= 1'b0;
      time_err_q  <= 1'b0;
      err_pulse_q <= 1'b0;
      cycles_q    <= '0;
    end else begin
      prev_q      <= bus.i_state;
      dwell_q     <= dwell_d;
      ns_lamp_q   <= ns_lamp_d;
      ew_lamp_q   <= ew_lamp_d;
      seq_err_q   <= seq_err_d;
      time_err_q  <= time_err_d;
      err_pulse_q <= seq_ev || time_ev;
      cycles_q    <= cycles_d;
    end
  end

  assign bus.o_ns_lamp   = ns_lamp_q;
  assign bus.o_ew_lamp   = ew_lamp_q;
  assign bus.o_seq_err   = seq_err_q;
  assign bus.o_time_err  = time_err_q;
  assign bus.o_err_pulse = err_pulse_q;
  assign bus.o_cycles    = cycles_q;
  assign bus.o_dwell     = dwell_q;

endmodule

// File: tb/tb_tl_monitor.sv
module tb_tl_monitor;

  localparam int T_WIDTH   = 8;
  localparam int CNT_WIDTH = 16;
  localparam int SAT       = (1 << T_WIDTH) - 1;

  localparam logic [2:0] START = 3'b111;
  localparam logic [2:0] NS    = 3'b011;
  localparam logic [2:0] NY    = 3'b010;
  localparam logic [2:0] EW    = 3'b000;
  localparam logic [2:0] EY    = 3'b001;

  typedef struct {
    logic [2:0]  ns;
    logic [2:0]  ew;
    logic        seq;
    logic        tim;
    logic        pulse;
    logic [31:0] cyc;
    logic [31:0] dwell;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  tl_monitor_if #(.T_WIDTH(T_WIDTH), .CNT_WIDTH(CNT_WIDTH)) tif ();

  tl_monitor #(
    .T_WIDTH  (T_WIDTH),
    .NS_CYCLES(9),
    .EW_CYCLES(6),
    .Y_CYCLES (3),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (tif.slave)
  );

  always #5 i_clk = ~i_clk;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 0;

  // Reference model: the monitor's view of the light, as plain integers.
  int m_prev = 7;
  int m_held = 0;
  bit m_seq  = 0;
  bit m_tim  = 0;
  int m_cyc  = 0;

  function automatic int req_dwell(input int code);
    case (code)
      3: return 9;
      0: return 6;
      2, 1: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int next_of(input int code);
    case (code)
      7: return 3;
      3: return 2;
      2: return 0;
      0: return 1;
      1: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [5:0] lamps_of(input int code);
    case (code)
      3: return 6'b001_100;
      2: return 6'b010_100;
      0: return 6'b100_001;
      1: return 6'b100_010;
      default: return 6'b100_100;
    endcase
  endfunction

  task automatic step(input logic rst, input logic [2:0] st, input logic clr);
    exp_t e;
    int   need;
    bit   serr, terr;
    logic [5:0] lp;
    @(negedge i_clk);
    i_rst       = rst;
    tif.i_state = st;
    tif.i_clr   = clr;
    serr = 0;
    terr = 0;
    if (rst) begin
      m_prev = 7; m_held = 0; m_seq = 0; m_tim = 0; m_cyc = 0;
      lp = 6'b100_100;
    end else begin
      need = req_dwell(m_prev);
      if (int'(st) == m_prev) begin
        if (need > 0 && m_held == need) terr = 1;
        if (m_held < SAT) m_held++;
      end else begin
        if (next_of(m_prev) != int'(st)) serr = 1;
        if (need > 0 && m_held < need) terr = 1;
        if (m_prev == 1 && int'(st) == 3) m_cyc = (m_cyc + 1) % (1 << CNT_WIDTH);
        m_prev = int'(st);
        m_held = 1;
      end
      m_seq = (m_seq && !clr) || serr;
      m_tim = (m_tim && !clr) || terr;
      lp = lamps_of(int'(st));
    end
    e.ns    = lp[5:3];
    e.ew    = lp[2:0];
    e.seq   = m_seq;
    e.tim   = m_tim;
    e.pulse = serr || terr;
    e.cyc   = m_cyc;
    e.dwell = m_held;
    sb.push_back(e);
  endtask

  task automatic hold(input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) step(1'b0, st, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, START, 1'b0);
    step(1'b1, START, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: every posedge the DUT presents the response to the previous sample.
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ns_lamp", 32'(tif.o_ns_lamp), 32'(e.ns));
        chk("ew_lamp", 32'(tif.o_ew_lamp), 32'(e.ew));
        chk("seq_err", 32'(tif.o_seq_err), 32'(e.seq));
        chk("time_err", 32'(tif.o_time_err), 32'(e.tim));
        chk("err_pulse", 32'(tif.o_err_pulse), 32'(e.pulse));
        chk("cycles", 32'(tif.o_cycles), e.cyc);
        chk("dwell", 32'(tif.o_dwell), e.dwell);
      end
    end
  end

  initial begin
    int cur;
    int nxt;
    int need;
    int len;
    tif.i_state = START;
    tif.i_clr   = 1'b0;

    // Nominal run: three clean cycles, then the EY->NS that completes the third.
    do_reset();
    hold(START, 3);
    for (int c = 0; c < 3; c++) begin
      hold(NS, 9); hold(NY, 3); hold(EW, 6); hold(EY, 3);
    end
    hold(NS, 2);

    // Short NS phase.
    do_reset();
    hold(START, 2); hold(NS, 8); hold(NY, 3);

    // Stuck EW phase.
    do_reset();
    hold(START, 2); hold(NS, 9); hold(NY, 3); hold(EW, 20); hold(EY, 3);

    // Illegal code held, then a skipped phase.
    do_reset();
    hold(START, 2); hold(3'b101, 4); hold(3'b110, 2);
    do_reset();
    hold(START, 2); hold(NS, 9); hold(EW, 6);

    // Clear coinciding with a short-dwell transition, then clear alone.
    do_reset();
    hold(START, 2); hold(NS, 7);
    step(1'b0, NY, 1'b1);
    step(1'b0, NY, 1'b1);
    hold(NY, 2);

    // Reset in the middle of EW, then a nominal cycle.
    do_reset();
    hold(START, 2); hold(NS, 9); hold(NY, 3); hold(EW, 2);
    step(1'b1, EW, 1'b0);
    hold(START, 3); hold(NS, 9); hold(NY, 3); hold(EW, 6); hold(EY, 3); hold(NS, 2);

    // Saturating dwell counter.
    do_reset();
    hold(START, 1); hold(NS, SAT + 5); hold(NY, 3);

    // Randomized phases with jittered dwell, occasional wrong codes, clears and resets.
    do_reset();
    cur = 7;
    for (int p = 0; p < 80; p++) begin
      nxt = next_of(cur);
      if (nxt < 0 || $urandom_range(0, 9) == 0) nxt = int'($urandom_range(0, 7));
      need = req_dwell(nxt);
      len = (need > 0) ? need - 1 + int'($urandom_range(0, 3)) : int'($urandom_range(1, 3));
      for (int k = 0; k < len; k++) begin
        step(($urandom_range(0, 99) == 0), 3'(nxt), ($urandom_range(0, 7) == 0));
      end
      cur = nxt;
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge i_clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
